// File: rtl/float_pkg.sv
// Shared widths, state encoding and the packed single-precision layout
// used by the float normalization stage.
package float_pkg;

    localparam int unsigned EXP_W   = 8;
    localparam int unsigned MAN_W   = 23;
    localparam int unsigned EXP_MAX = 255;
    localparam int unsigned BIAS    = 127;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] frac;
    } fp32_t;

endpackage

// File: rtl/float_normalizer_if.sv
// Valid/ready bundle between the adder mantissa datapath, the normalizer
// and its consumer.
interface float_normalizer_if;
    import float_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic                 in_sign;
    logic [EXP_W-1:0]     in_exp;
    logic [MAN_W+1:0]     in_mant;
    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_result;
    logic                 out_exception;

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, out_ready,
        output in_ready, out_valid, out_result, out_exception
    );

    modport master (
        output in_valid, in_sign, in_exp, in_mant, out_ready,
        input  in_ready, out_valid, out_result, out_exception
    );

endinterface

// File: rtl/carrySelectAdder.sv
// Carry-select adder: ripple lower half, upper half precomputed for both
// carry values and selected by the lower-half carry.
module carrySelectAdder #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int unsigned LO = W / 2;
    localparam int unsigned HI = W - LO;

    logic [LO:0] lo_sum;
    logic [HI:0] hi_sum0;
    logic [HI:0] hi_sum1;

    always_comb begin
        lo_sum  = {1'b0, a[LO-1:0]} + {1'b0, b[LO-1:0]} + {{LO{1'b0}}, cin};
        hi_sum0 = {1'b0, a[W-1:LO]} + {1'b0, b[W-1:LO]};
        hi_sum1 = {1'b0, a[W-1:LO]} + {1'b0, b[W-1:LO]} + {{HI{1'b0}}, 1'b1};
        if (lo_sum[LO]) begin
            sum  = {hi_sum1[HI-1:0], lo_sum[LO-1:0]};
            cout = hi_sum1[HI];
        end else begin
            sum  = {hi_sum0[HI-1:0], lo_sum[LO-1:0]};
            cout = hi_sum0[HI];
        end
    end

endmodule

// File: rtl/float_normalizer.sv
// Multi-cycle normalizer: shifts the adder mantissa one bit per cycle until
// the hidden bit is set or the exponent floor is hit, then packs an fp32 word.
module float_normalizer
    import float_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    float_normalizer_if.slave   bus
);

    state_t           state_q, state_d;
    logic             sign_q, sign_d;
    logic [EXP_W:0]   exp_q, exp_d;
    logic [MAN_W+1:0] mant_q, mant_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      result_q, result_d;
    logic             exception_q, exception_d;

    logic [EXP_W-1:0] add_a, add_b, add_sum;
    logic             add_cout;
    logic             exc_c;
    fp32_t            packed_c;

    // One adder serves both the carry increment (b=0) and the shift decrement (b=~1)
    carrySelectAdder #(.W(EXP_W)) u_exp_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (1'b1),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        add_a = (state_q == IDLE) ? bus.in_exp : exp_q[EXP_W-1:0];
        add_b = (state_q == SHIFT) ? ~EXP_W'(1) : '0;
    end

    // Exception covers both an all-ones input exponent and a carry overflow
    always_comb begin
        exc_c         = (exp_q >= (EXP_W+1)'(EXP_MAX));
        packed_c.sign = sign_q;
        packed_c.exp  = mant_q[MAN_W] ? exp_q[EXP_W-1:0] : '0;
        packed_c.frac = mant_q[MAN_W-1:0];
    end

    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        mant_d      = mant_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        exception_d = exception_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    sign_d  = bus.in_sign;
                    exp_d   = {1'b0, bus.in_exp};
                    mant_d  = bus.in_mant;
                    state_d = DONE;
                    if (bus.in_exp == EXP_W'(EXP_MAX)) begin
                        state_d = DONE;
                    end else if (bus.in_mant == '0) begin
                        state_d = DONE;
                    end else if (bus.in_mant[MAN_W+1]) begin
                        mant_d = bus.in_mant >> 1;
                        exp_d  = {add_cout, add_sum};
                    end else if (bus.in_mant[MAN_W]) begin
                        state_d = DONE;
                    end else if (bus.in_exp <= EXP_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                mant_d = mant_q << 1;
                exp_d  = {1'b0, add_sum};
                if (mant_q[MAN_W-1] || (add_sum == EXP_W'(1))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    exception_d = exc_c;
                    result_d    = (exc_c || (mant_q == '0)) ? 32'h0 : 32'(packed_c);
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            mant_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            exception_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            mant_q      <= mant_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            exception_q <= exception_d;
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_result    = result_q;
    assign bus.out_exception = exception_q;

endmodule

// File: doc/float_normalizer.md
# float_normalizer

Sequential normalization stage that sits directly downstream of the floating-point adder's mantissa datapath. Each transaction is an unnormalized 25-bit mantissa (bit 24 = carry-out), an 8-bit exponent and a sign. The block shifts the mantissa one position per cycle until the hidden bit (bit 23) is set or the exponent floor is reached, then presents a packed IEEE-754 single-precision word. It replaces the single-cycle priority-encoder path with a valid/ready stage that closes timing at higher clock rates.

## Interface
- EXP_W, 8, exponent field width
- MAN_W, 23, stored-fraction width; mantissa input is MAN_W+2 bits
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input transaction present
- in_ready  out  1  block can accept; high only in IDLE and while rst low
- in_sign  in  1  result sign
- in_exp  in  EXP_W  pre-normalization exponent (biased)
- in_mant  in  MAN_W+2  unnormalized mantissa; bit 24 carry, bit 23 hidden-bit position
- out_valid  out  1  result available; held until accepted
- out_ready  in  1  consumer accepts
- out_result  out  32  {sign, exp field, fraction}
- out_exception  out  1  exponent overflowed, or input exponent all-ones

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: accept on in_valid && in_ready; capture sign/exp/mant, then classify:
  - in_exp == 255 -> exception, result 32'h0, go DONE.
  - mant == 0 -> result 32'h0 (positive zero, sign dropped), exception 0, go DONE.
  - mant[24] == 1 -> mant >>= 1 (bit 0 truncated), exp += 1; if new exp == 255 -> exception, result 0; go DONE.
  - mant[23] == 1 -> go DONE unchanged.
  - exp <= 1 -> go DONE (denormal).
  - otherwise go SHIFT.
- SHIFT: each cycle mant <<= 1, exp -= 1. Go DONE when post-shift mant[23] == 1 or post-shift exp == 1; otherwise stay.
- Packing: exp field = exp if mant[23] else 0; fraction = mant[22:0]; sign = captured sign. Exception or zero forces out_result = 0.
- DONE: out_valid = 1. out_result and out_exception are stable. On out_ready go IDLE.
- Arithmetic: exp is held in EXP_W+1 bits internally so overflow is detectable. Rounding mode is truncation, consistent with the adder.

## Timing
- Reset values: state IDLE, out_valid 0, out_result 0, out_exception 0, internal regs 0. in_ready is 0 while rst is high and 1 on the first cycle after.
- Latency from the capture edge to out_valid: 1 cycle when no left shift is needed; k+1 cycles for k left shifts. Worst case is 24 cycles (23 shifts).
- Throughput: one transaction per latency+1 cycles minimum. A new input cannot be accepted in the same cycle out_valid drops; no bypass.
- in_ready is registered-state-derived only. There is no combinational path from out_ready to in_ready.
- Back-pressure: while out_valid && !out_ready, all outputs are held bit-stable.
- Reset mid-SHIFT or mid-DONE: transaction is dropped, and outputs return to reset values on the next edge.
- in_valid while in SHIFT/DONE is ignored; the producer must hold its data.

## Structure
- Shared package float_pkg holds:
  - EXP_W, MAN_W, EXP_MAX (255), BIAS (127)
  - the state enum {IDLE, SHIFT, DONE}
  - a packed fp32 struct {sign, exp, frac}
- Sub-module: reuse carrySelectAdder #(8) for exponent increment/decrement (carry-in 1 with inverted operand for decrement). Mantissa shifting stays in this module.

## Test plan
- Already normalized: exp 0x80, mant 0x0800000, sign 0 -> out_result 0x40000000, out_valid 1 cycle after capture, exception 0.
- Carry: exp 0x7F, mant 0x1800000 -> out_result 0x40400000 (3.0) after 1 cycle.
- Cancellation: exp 0x82, mant 0x0200000, sign 1 -> 2 shifts, out_result 0xC0000000, out_valid 3 cycles after capture.
- Denormal floor: exp 0x03, mant 0x0000010 -> stops at exp 1, out_result 0x00000040. Separately, mant 0 with exp 0x90 -> out_result 0x00000000 after 1 cycle.
- Overflow and exception:
  - exp 0xFE, mant 0x1000000 -> out_exception 1, out_result 0.
  - exp 0xFF, any mant -> out_exception 1.
- Handshake and reset:
  - Hold out_ready low 5 cycles in DONE -> outputs stable, in_ready 0.
  - Assert rst for 1 cycle during SHIFT -> next cycle out_valid 0, out_result 0, in_ready 1 after release; the next transaction is processed normally.
